// File: rtl/cle_sram_arbiter.sv
// -----------------------------------------------------------------------------
// cle_sram_arbiter
//
// Purpose: shares the single-port 1024 x 8 label SRAM between the two CLE
// engines (0 = raster-scan/label-write, 1 = BFS/relabel). The arbiter grants
// round-robin, registers the winning access onto the SRAM pins (stage 1), and
// two cycles after the grant returns read data to the owning requester
// (stage 2).
//
// Handshake (valid/ready): reqX is the valid, gntX is the ready. A request
// transfers in the cycle where reqX && gntX. gntX is combinational from
// req0/req1 and the priority pointer and is forced low while reset is high.
// A requester holds req/we/addr/wdata stable until it is granted.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   req/we/addr/wdata 0,1      requester access request, direction, address, data
//   gnt0, gnt1                 request accepted this cycle (combinational)
//   rvalid0/rdata0, rvalid1/rdata1  read return, rdata holds while rvalid low
//   sram_a, sram_d, sram_wen   registered SRAM address, write data, write enable
//   sram_q                     SRAM read data, valid one cycle after sram_a
//   busy                       stage 1 or stage 2 occupied
//   dbg_state                  {pointer, stage-1 occupied, stage-2 occupied}
//
// Optional build macro CLE_ARB_STATS_EN adds saturating 16-bit counters
// cnt_gnt0, cnt_gnt1 (grants per requester) and cnt_conflict (cycles with
// both requests high).
// -----------------------------------------------------------------------------
module cle_sram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen,
  input  logic [DW-1:0] sram_q,
`ifdef CLE_ARB_STATS_EN
  output logic [15:0]   cnt_gnt0,
  output logic [15:0]   cnt_gnt1,
  output logic [15:0]   cnt_conflict,
`endif
  output logic          busy,
  output logic [2:0]    dbg_state
);

  typedef enum logic {
    ST_EMPTY    = 1'b0,
    ST_OCCUPIED = 1'b1
  } stage_state_e;

  stage_state_e s1_state_q, s1_state_d;
  stage_state_e s2_state_q, s2_state_d;

  // ptr_q names the preferred requester on a conflict: the one not granted last.
  logic          ptr_q, ptr_d;
  logic          s1_owner_q, s1_owner_d;
  logic          s1_read_q, s1_read_d;
  logic          s2_owner_q, s2_owner_d;
  logic [AW-1:0] sram_a_q, sram_a_d;
  logic [DW-1:0] sram_d_q, sram_d_d;
  logic          sram_wen_q, sram_wen_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          grant;
  logic          g_owner;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  // Arbitration and winner mux.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || !ptr_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    grant   = gnt0 | gnt1;
    g_owner = gnt1;
    g_we    = gnt1 ? we1    : we0;
    g_addr  = gnt1 ? addr1  : addr0;
    g_wdata = gnt1 ? wdata1 : wdata0;
  end

  // Next-state for pointer and both pipeline stages; stages advance every cycle.
  always_comb begin
    ptr_d      = ptr_q;
    s1_state_d = ST_EMPTY;
    s1_owner_d = s1_owner_q;
    s1_read_d  = 1'b0;
    sram_a_d   = sram_a_q;
    sram_d_d   = sram_d_q;
    sram_wen_d = 1'b0;
    s2_state_d = ST_EMPTY;
    s2_owner_d = s1_owner_q;

    if (grant) begin
      ptr_d      = ~g_owner;
      s1_state_d = ST_OCCUPIED;
      s1_owner_d = g_owner;
      s1_read_d  = ~g_we;
      sram_a_d   = g_addr;
      sram_wen_d = g_we;
      if (g_we) begin
        sram_d_d = g_wdata;
      end
    end

    // Only reads occupy stage 2; writes retire once they hit the pins.
    if (s1_state_q == ST_OCCUPIED && s1_read_q) begin
      s2_state_d = ST_OCCUPIED;
    end
  end

  // Read return: sram_q is live in stage 2, the per-owner holding register
  // keeps the last value when no data is returning.
  always_comb begin
    rvalid0  = (s2_state_q == ST_OCCUPIED) && !s2_owner_q;
    rvalid1  = (s2_state_q == ST_OCCUPIED) &&  s2_owner_q;
    rdata0   = rvalid0 ? sram_q : rdata0_q;
    rdata1   = rvalid1 ? sram_q : rdata1_q;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      s1_state_q <= ST_EMPTY;
      s1_owner_q <= 1'b0;
      s1_read_q  <= 1'b0;
      s2_state_q <= ST_EMPTY;
      s2_owner_q <= 1'b0;
      sram_a_q   <= '0;
      sram_d_q   <= '0;
      sram_wen_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_state_q <= s1_state_d;
      s1_owner_q <= s1_owner_d;
      s1_read_q  <= s1_read_d;
      s2_state_q <= s2_state_d;
      s2_owner_q <= s2_owner_d;
      sram_a_q   <= sram_a_d;
      sram_d_q   <= sram_d_d;
      sram_wen_q <= sram_wen_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign sram_a    = sram_a_q;
  assign sram_d    = sram_d_q;
  assign sram_wen  = sram_wen_q;
  assign busy      = (s1_state_q == ST_OCCUPIED) || (s2_state_q == ST_OCCUPIED);
  assign dbg_state = {ptr_q, s1_state_q == ST_OCCUPIED, s2_state_q == ST_OCCUPIED};

`ifdef CLE_ARB_STATS_EN
  logic [15:0] cnt_gnt0_q, cnt_gnt1_q, cnt_conflict_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_gnt0_q     <= '0;
      cnt_gnt1_q     <= '0;
      cnt_conflict_q <= '0;
    end else begin
      if (gnt0 && cnt_gnt0_q != 16'hFFFF) begin
        cnt_gnt0_q <= cnt_gnt0_q + 16'd1;
      end
      if (gnt1 && cnt_gnt1_q != 16'hFFFF) begin
        cnt_gnt1_q <= cnt_gnt1_q + 16'd1;
      end
      if (req0 && req1 && cnt_conflict_q != 16'hFFFF) begin
        cnt_conflict_q <= cnt_conflict_q + 16'd1;
      end
    end
  end

  assign cnt_gnt0     = cnt_gnt0_q;
  assign cnt_gnt1     = cnt_gnt1_q;
  assign cnt_conflict = cnt_conflict_q;
`endif

endmodule

// File: tb/tb_cle_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cle_sram_arbiter
//
// Directed scenarios plus a randomized run for cle_sram_arbiter. The bench
// owns a behavioural SRAM (registered read) and a reference model: a label
// memory updated in grant order, the last winner, and a queue of expected
// read returns tagged with owner and due cycle.
// -----------------------------------------------------------------------------
module tb_cle_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, sram_wen, busy;
  logic [DW-1:0] rdata0, rdata1, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic [2:0]    dbg_state;
`ifdef CLE_ARB_STATS_EN
  logic [15:0]   cnt_gnt0, cnt_gnt1, cnt_conflict;
`endif

  cle_sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q),
`ifdef CLE_ARB_STATS_EN
    .cnt_gnt0(cnt_gnt0), .cnt_gnt1(cnt_gnt1), .cnt_conflict(cnt_conflict),
`endif
    .busy(busy), .dbg_state(dbg_state)
  );

  // Behavioural single-port SRAM: read data one cycle after the address.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_a] <= sram_d;
    sram_q <= mem[sram_a];
  end

  // Reference model and scoreboard
  logic [DW-1:0] ref_mem [1024];
  int            last_winner;
  logic [DW-1:0] exp_q[$];
  bit            exp_own_q[$];
  int            exp_cyc_q[$];

  int passed = 0;
  int total  = 0;

  // Round robin rule: a lone requester wins; on a conflict the requester that
  // did not win last time wins. Returns -1 when nobody requests.
  function automatic int exp_winner(bit r0, bit r1);
    if (r0 && r1) return (last_winner == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    last_winner = 1;
  endtask

  task automatic test_reset();
    // A write presented while reset is high must not be performed.
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd9; wdata0 = 8'h5A;
    tick();
    #1;
    total++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt0 got=%b exp=0", gnt0); else passed++;
    total++; if (gnt1 !== 1'b0) $display("FAIL rst_gnt1 got=%b exp=0", gnt1); else passed++;
    total++; if (sram_wen !== 1'b0) $display("FAIL rst_wen got=%b exp=0", sram_wen); else passed++;
    total++; if (sram_a !== 10'd0) $display("FAIL rst_sram_a got=%0d exp=0", sram_a); else passed++;
    total++; if (sram_d !== 8'd0) $display("FAIL rst_sram_d got=%0h exp=0", sram_d); else passed++;
    total++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL rst_rvalid got=%b exp=00", {rvalid0, rvalid1}); else passed++;
    total++; if ({rdata0, rdata1} !== 16'h0000) $display("FAIL rst_rdata got=%h exp=0000", {rdata0, rdata1}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
    // Release reset and read the address back: the old contents must remain.
    reset = 1'b0; last_winner = 1;
    we0 = 1'b0;
    #1;
    total++; if (gnt0 !== 1'b1) $display("FAIL rst_rd_gnt0 got=%b exp=1", gnt0); else passed++;
    last_winner = 0;
    tick();
    req0 = 1'b0;
    total++; if (sram_wen !== 1'b0 || sram_a !== 10'd9) $display("FAIL rst_rd_pins got=%b/%0d exp=0/9", sram_wen, sram_a); else passed++;
    tick();
    total++; if (rvalid0 !== 1'b1 || rdata0 !== ref_mem[9]) $display("FAIL rst_no_write got=%b/%h exp=1/%h", rvalid0, rdata0, ref_mem[9]); else passed++;
  endtask

  task automatic test_write_read();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd5; wdata0 = 8'h03;
    #1;
    total++; if (gnt0 !== 1'b1) $display("FAIL wr_gnt0 got=%b exp=1", gnt0); else passed++;
    ref_mem[5] = 8'h03;
    tick();
    total++; if (sram_wen !== 1'b1 || sram_a !== 10'd5 || sram_d !== 8'h03) $display("FAIL wr_pins got=%b/%0d/%h exp=1/5/03", sram_wen, sram_a, sram_d); else passed++;
    we0 = 1'b0;
    #1;
    total++; if (gnt0 !== 1'b1) $display("FAIL rd_gnt0 got=%b exp=1", gnt0); else passed++;
    tick();
    req0 = 1'b0;
    total++; if (sram_wen !== 1'b0 || sram_a !== 10'd5) $display("FAIL rd_pins got=%b/%0d exp=0/5", sram_wen, sram_a); else passed++;
    total++; if (rvalid0 !== 1'b0) $display("FAIL rd_early_rvalid got=%b exp=0", rvalid0); else passed++;
    tick();
    total++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h03) $display("FAIL raw_rdata got=%b/%h exp=1/03", rvalid0, rdata0); else passed++;
    total++; if (rvalid1 !== 1'b0) $display("FAIL raw_rvalid1 got=%b exp=0", rvalid1); else passed++;
    tick();
    total++; if (rvalid0 !== 1'b0 || rdata0 !== 8'h03) $display("FAIL rdata_hold got=%b/%h exp=0/03", rvalid0, rdata0); else passed++;
  endtask

  task automatic test_contention();
    logic [AW-1:0] a_exp;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        a_exp = (i % 2 == 1) ? 10'd100 : 10'd200;
        total++; if (sram_a !== a_exp) $display("FAIL cont_sram_a%0d got=%0d exp=%0d", i, sram_a, a_exp); else passed++;
      end
      #1;
      total++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) $display("FAIL cont_gnt%0d got=%b%b exp=%b%b", i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1)); else passed++;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    total++; if (sram_a !== 10'd200) $display("FAIL cont_sram_a4 got=%0d exp=200", sram_a); else passed++;
`ifdef CLE_ARB_STATS_EN
    total++; if (cnt_conflict !== 16'd4) $display("FAIL cont_cnt_conflict got=%0d exp=4", cnt_conflict); else passed++;
    total++; if (cnt_gnt0 !== 16'd2 || cnt_gnt1 !== 16'd2) $display("FAIL cont_cnt_gnt got=%0d/%0d exp=2/2", cnt_gnt0, cnt_gnt1); else passed++;
`endif
    tick(); tick();
  endtask

  task automatic test_read_routing();
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd1023;
    #1;
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) $display("FAIL route_gnt got=%b%b exp=01", gnt0, gnt1); else passed++;
    tick();
    req1 = 1'b0;
    total++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL route_early got=%b exp=00", {rvalid0, rvalid1}); else passed++;
    tick();
    total++; if (rvalid1 !== 1'b1 || rdata1 !== 8'hAA) $display("FAIL route_rdata1 got=%b/%h exp=1/aa", rvalid1, rdata1); else passed++;
    total++; if (rvalid0 !== 1'b0) $display("FAIL route_rvalid0 got=%b exp=0", rvalid0); else passed++;
    tick();
  endtask

  task automatic test_idle_hold();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd7; wdata0 = 8'h77;
    #1;
    total++; if (gnt0 !== 1'b1) $display("FAIL idle_gnt0 got=%b exp=1", gnt0); else passed++;
    ref_mem[7] = 8'h77;
    tick();
    req0 = 1'b0;
    total++; if (busy !== 1'b1 || sram_wen !== 1'b1 || sram_a !== 10'd7) $display("FAIL idle_wr got=%b/%b/%0d exp=1/1/7", busy, sram_wen, sram_a); else passed++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (sram_wen !== 1'b0 || sram_a !== 10'd7 || sram_d !== 8'h77) $display("FAIL idle_hold%0d got=%b/%0d/%h exp=0/7/77", k, sram_wen, sram_a, sram_d); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL idle_busy%0d got=%b exp=0", k, busy); else passed++;
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    // Grant requester 0 first so the pointer moves toward requester 1.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd3;
    #1;
    total++; if (gnt0 !== 1'b1) $display("FAIL mid_gnt0 got=%b exp=1", gnt0); else passed++;
    tick();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd1023;
    #1;
    total++; if (gnt1 !== 1'b1) $display("FAIL mid_gnt1 got=%b exp=1", gnt1); else passed++;
    tick();
    req1 = 1'b0;
    reset = 1'b1;
    tick();
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0;
    #1;
    total++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL mid_gnt_in_reset got=%b exp=00", {gnt0, gnt1}); else passed++;
    total++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) $display("FAIL mid_rvalid got=%b%b exp=00", rvalid0, rvalid1); else passed++;
    total++; if (sram_wen !== 1'b0 || sram_a !== 10'd0 || sram_d !== 8'd0) $display("FAIL mid_pins got=%b/%0d/%h exp=0/0/00", sram_wen, sram_a, sram_d); else passed++;
    total++; if (busy !== 1'b0 || rdata0 !== 8'd0 || rdata1 !== 8'd0) $display("FAIL mid_busy_rdata got=%b/%h/%h exp=0/00/00", busy, rdata0, rdata1); else passed++;
    reset = 1'b0;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL mid_ptr got=%b%b exp=10", gnt0, gnt1); else passed++;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    total++; if (rvalid1 !== 1'b0) $display("FAIL mid_stale_rvalid1 got=%b exp=0", rvalid1); else passed++;
    tick(); tick();
  endtask

  task automatic test_random();
    bit            pend [2];
    bit            pwe [2];
    logic [AW-1:0] paddr [2];
    logic [DW-1:0] pwd [2];
    bit            prev_v;
    bit            prev_we;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;
    bit            due;
    bit            due_own;
    logic [DW-1:0] due_d;
    int            w;
    int            dummy;
    do_reset();
    pend[0] = 0; pend[1] = 0; pwe[0] = 0; pwe[1] = 0;
    paddr[0] = '0; paddr[1] = '0; pwd[0] = '0; pwd[1] = '0;
    prev_v = 0; prev_we = 0; prev_a = '0; prev_d = '0;
    held_a = '0; held_d = '0;
    exp_q.delete(); exp_own_q.delete(); exp_cyc_q.delete();
    for (int c = 0; c < 400; c++) begin
      // Registered outputs for this cycle.
      if (prev_v) begin
        held_a = prev_a;
        if (prev_we) held_d = prev_d;
      end
      total++; if (sram_wen !== (prev_v && prev_we)) $display("FAIL rnd_wen c=%0d got=%b exp=%b", c, sram_wen, prev_v && prev_we); else passed++;
      total++; if (sram_a !== held_a) $display("FAIL rnd_sram_a c=%0d got=%0d exp=%0d", c, sram_a, held_a); else passed++;
      total++; if (sram_d !== held_d) $display("FAIL rnd_sram_d c=%0d got=%h exp=%h", c, sram_d, held_d); else passed++;
      due = 0; due_own = 0; due_d = '0;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == c) begin
        due = 1;
        due_own = exp_own_q.pop_front();
        due_d = exp_q.pop_front();
        dummy = exp_cyc_q.pop_front();
      end
      total++; if (rvalid0 !== (due && !due_own) || rvalid1 !== (due && due_own)) $display("FAIL rnd_rvalid c=%0d got=%b%b exp=%b%b", c, rvalid0, rvalid1, due && !due_own, due && due_own); else passed++;
      if (due) begin
        total++; if ((due_own ? rdata1 : rdata0) !== due_d) $display("FAIL rnd_rdata c=%0d own=%0d got=%h exp=%h", c, due_own, due_own ? rdata1 : rdata0, due_d); else passed++;
      end
      total++; if (busy !== (prev_v || due)) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, prev_v || due); else passed++;
      // New stimulus: an idle requester may raise a fresh request.
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && c < 396 && $urandom_range(0, 99) < 60) begin
          pend[r] = 1;
          pwe[r] = 1'($urandom_range(0, 1));
          paddr[r] = 10'($urandom_range(0, 15));
          pwd[r] = 8'($urandom_range(0, 255));
        end
      end
      req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwd[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwd[1];
      #1;
      w = exp_winner(pend[0], pend[1]);
      total++; if (gnt0 !== (w == 0) || gnt1 !== (w == 1)) $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, gnt0, gnt1, w == 0, w == 1); else passed++;
      prev_v = (w >= 0);
      if (w >= 0) begin
        prev_we = pwe[w]; prev_a = paddr[w]; prev_d = pwd[w];
        if (pwe[w]) begin
          ref_mem[paddr[w]] = pwd[w];
        end else begin
          exp_q.push_back(ref_mem[paddr[w]]);
          exp_own_q.push_back(w == 1);
          exp_cyc_q.push_back(c + 2);
        end
        last_winner = w;
        pend[w] = 0;
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    total++; if (exp_q.size() != 0) $display("FAIL rnd_drain left=%0d exp=0", exp_q.size()); else passed++;
  endtask

`ifdef CLE_ARB_STATS_EN
  task automatic test_stats_saturation();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd0;
    repeat (70000) @(posedge clk);
    #1;
    req0 = 1'b0;
    total++; if (cnt_gnt0 !== 16'hFFFF) $display("FAIL stat_gnt0 got=%h exp=ffff", cnt_gnt0); else passed++;
    total++; if (cnt_gnt1 !== 16'h0000) $display("FAIL stat_gnt1 got=%h exp=0000", cnt_gnt1); else passed++;
    total++; if (cnt_conflict !== 16'h0000) $display("FAIL stat_conflict got=%h exp=0000", cnt_conflict); else passed++;
    tick(); tick();
  endtask
`endif

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom_range(0, 255);
      mem[i] = 8'(v);
      ref_mem[i] = 8'(v);
    end
    mem[9] = 8'h11;      ref_mem[9] = 8'h11;
    mem[1023] = 8'hAA;   ref_mem[1023] = 8'hAA;
    last_winner = 1;

    test_reset();
    test_write_read();
    test_contention();
    test_read_routing();
    test_idle_hold();
    test_reset_mid_read();
    test_random();
`ifdef CLE_ARB_STATS_EN
    test_stats_saturation();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
